// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    typedef enum logic {FETCH, DRAIN} e_fetch_state;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two FIFO with synchronous clear; head is read straight from storage
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;
    always_comb begin
        do_pop  = pop && count_q != '0;
        wr_d    = clr ? '0 : wr_q + AW'(push);
        rd_d    = clr ? '0 : rd_q + AW'(do_pop);
        count_d = clr ? '0 : count_q + CW'(push) - CW'(do_pop);
        dout    = mem_q[rd_q];
        count   = count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
        if (push && !clr) mem_q[wr_q] <= din;
    end
    always_ff @(posedge clk)
        if (!rst && !clr && push && !do_pop) assert (count_q != CW'(DEPTH));
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner issuing word reads and queueing returned instructions toward decode
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    e_fetch_state      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, tag_head;
    logic [2*XLEN-1:0] head;
    logic [CW-1:0]     count, outstanding, outstanding_d;
    logic              req_fire, rsp_take, push, pop;
    always_comb begin
        imem_req_valid = !rst && state_q == FETCH
                         && ({1'b0, outstanding} + {1'b0, count} < (CW+1)'(DEPTH));
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_take       = imem_rsp_valid && outstanding != '0;
        push           = rsp_take && state_q == FETCH && !redirect_valid;
        inst_valid     = count != '0 && !redirect_valid;
        pop            = inst_valid && inst_ready;
        outstanding_d  = outstanding + CW'(req_fire) - CW'(rsp_take);
        pc_d           = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00}
                       : req_fire ? pc_q + 32'd4 : pc_q;
        // stale responses must drain before fetching resumes after a redirect
        state_d        = outstanding_d != '0 && (redirect_valid || state_q == DRAIN) ? DRAIN : FETCH;
        inst_data      = count != '0 ? head[2*XLEN-1:XLEN] : INST_NOP;
        inst_pc        = count != '0 ? head[XLEN-1:0] : RESET_PC;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
    // tag queue is never flushed: its occupancy is the outstanding-request count
    fetch_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .push  (req_fire),
        .din   (pc_q),
        .pop   (imem_rsp_valid),
        .dout  (tag_head),
        .count (outstanding)
    );
    fetch_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_inst_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect_valid),
        .push  (push),
        .din   ({imem_rsp_data, tag_head}),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );
endmodule
